// File: rtl/mem_req_ctrl_if.sv
// Host request/response and memory command bundle for mem_req_ctrl.
// slave = the controller's view, master = the host/memory environment's view.
interface mem_req_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    // host request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    // host response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    // memory command port
    logic                  rd_wr_valid;
    logic                  rd_wr_mem;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    // status
    logic                  busy;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data,
        output req_ready, rsp_valid, rsp_rdata, rd_wr_valid, rd_wr_mem,
               mem_addr, wr_data, busy
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rd_wr_valid, rd_wr_mem,
               mem_addr, wr_data, busy
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller: IDLE -> CMD -> (WAIT -> RESP) -> IDLE.
// Define MEM_REQ_CTRL_WR_ACK_EN to make writes return a zero-data response beat.
module mem_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_req_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_wr_mem_q, rd_wr_mem_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  accept;
    logic                  req_ready_o;
    logic                  busy_o;
    logic                  rd_wr_valid_o;
    logic                  rsp_valid_o;

    assign accept = bus.req_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (rd_wr_mem_q) begin
`ifdef MEM_REQ_CTRL_WR_ACK_EN
                    state_d = RESP;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and strobe outputs decode straight from the state so reset clears them at once.
    always_comb begin
        req_ready_o   = 1'b0;
        busy_o        = 1'b1;
        rd_wr_valid_o = 1'b0;
        rsp_valid_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            CMD: begin
                rd_wr_valid_o = 1'b1;
            end
            WAIT: begin
            end
            RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rd_wr_mem_d = rd_wr_mem_q;
        mem_addr_d  = mem_addr_q;
        wr_data_d   = wr_data_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rd_wr_mem_d = bus.req_wr;
            mem_addr_d  = bus.req_addr;
            wr_data_d   = bus.req_wdata;
        end
        // Memory returns read data one cycle after the strobe, i.e. during WAIT.
        if (state_q == WAIT) begin
            rsp_rdata_d = bus.rd_data;
        end
`ifdef MEM_REQ_CTRL_WR_ACK_EN
        if ((state_q == CMD) && rd_wr_mem_q) begin
            rsp_rdata_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_wr_mem_q <= 1'b0;
            mem_addr_q  <= '0;
            wr_data_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rd_wr_mem_q <= rd_wr_mem_d;
            mem_addr_q  <= mem_addr_d;
            wr_data_q   <= wr_data_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready   = req_ready_o;
    assign bus.busy        = busy_o;
    assign bus.rd_wr_valid = rd_wr_valid_o;
    assign bus.rsp_valid   = rsp_valid_o;
    assign bus.rd_wr_mem   = rd_wr_mem_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized scoreboard bench for mem_req_ctrl with a word-memory model behind it.
// Driver works at posedge+1, monitor samples on the negedge.
module tb_mem_req_ctrl;
    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { logic [DW-1:0] d; int lat; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(string nm, string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (t=%0t)", nm, why, $time);
    endtask

    // Untouched memory words hold an address-derived pattern.
    function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Memory environment: writes on the strobe, read data valid the next cycle.
    always @(posedge clk) begin
        if (bus.rd_wr_valid) begin
            if (bus.rd_wr_mem) begin
                env_mem[bus.mem_addr] = bus.wr_data;
            end else begin
                bus.rd_data <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : pat(bus.mem_addr);
            end
        end
    end

    // Monitor / scoreboard
    int             cyc = 0;
    int             acc_cyc = 0;
    bit             prev_rv = 1'b0;
    bit             prev_stall = 1'b0;
    bit             prev_cmd = 1'b0;
    logic [DW-1:0]  prev_rdata = '0;
    logic [48:0]    hold = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_rv    = 1'b0;
            prev_stall = 1'b0;
            prev_cmd   = 1'b0;
            hold       = '0;
        end else begin
            chk("ready_vs_busy", {63'd0, bus.req_ready}, {63'd0, ~bus.busy});
            chk("cmd_regs_hold", {15'd0, bus.rd_wr_mem, bus.mem_addr, bus.wr_data}, {15'd0, hold});
            if (bus.rd_wr_valid) begin
                chk("strobe_one_cycle", {63'd0, prev_cmd}, 64'd0);
                if (cmd_q.size() == 0) begin
                    fail_now("unexpected_cmd", "rd_wr_valid with no request pending");
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    chk("cmd_type", {63'd0, bus.rd_wr_mem}, {63'd0, c.wr});
                    chk("cmd_addr", {48'd0, bus.mem_addr}, {48'd0, c.a});
                    chk("cmd_data", {32'd0, bus.wr_data}, {32'd0, c.d});
                    chk("cmd_latency", 64'(cyc - acc_cyc), 64'd1);
                end
            end
            if (prev_stall) begin
                chk("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
                chk("stall_rdata", {32'd0, bus.rsp_rdata}, {32'd0, prev_rdata});
                chk("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
            end
            if (bus.rsp_valid && !prev_rv) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp", "rsp_valid with no response pending");
                end else begin
                    chk("rsp_latency", 64'(cyc - acc_cyc), 64'(rsp_q[0].lat));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && rsp_q.size() != 0) begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, r.d});
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc;
                hold    = {bus.req_wr, bus.req_addr, bus.req_wdata};
            end
            prev_rv    = bus.rsp_valid;
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_rdata = bus.rsp_rdata;
            prev_cmd   = bus.rd_wr_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!bus.req_ready) begin
            step();
            n++;
            if (n > 50) begin
                fail_now("req_ready_timeout", "controller never returned to idle");
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_txn(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int stall);
        bit ok;
        bit resp;
        int n;
        wait_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        cmd_q.push_back('{wr, a, d});
        resp = 1'b0;
        if (!wr) begin
            rsp_q.push_back('{ref_read(a), 3});
            resp = 1'b1;
        end else begin
            ref_mem[a] = d;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
            rsp_q.push_back('{'0, 2});
            resp = 1'b1;
`endif
        end
        step();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
        if (resp) begin
            n = 0;
            while (!bus.rsp_valid) begin
                step();
                n++;
                if (n > 20) begin
                    fail_now("rsp_timeout", "no response beat");
                    return;
                end
            end
            for (int i = 0; i < stall; i++) begin
                bus.rsp_ready = 1'b0;
                bus.req_valid = 1'b1;
                bus.req_addr  = AW'($urandom);
                bus.req_wdata = $urandom;
                step();
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.rd_data   = '0;

        #12;
        chk("rst_rd_wr_valid", {63'd0, bus.rd_wr_valid}, 64'd0);
        chk("rst_mem_addr", {48'd0, bus.mem_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rel_busy", {63'd0, bus.busy}, 64'd0);

        do_txn(1'b1, 16'h0010, 32'hDEADBEEF, 0);
        do_txn(1'b0, 16'h0010, 32'h1234_5678, 0);
        do_txn(1'b0, 16'h0010, 32'h0BAD_F00D, 5);
        do_txn(1'b0, 16'hFFFF, 32'h0000_0001, 1);
        do_txn(1'b1, 16'hFFFF, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 16'hFFFF, 32'h0000_0002, 0);
`ifdef MEM_REQ_CTRL_WR_ACK_EN
        do_txn(1'b1, 16'h0001, 32'h5555_AAAA, 2);
`endif

        // Abort a read while it sits in WAIT.
        wait_ready(ok);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = 32'h7777_7777;
        cmd_q.push_back('{1'b0, 16'h0010, 32'h7777_7777});
        step();
        bus.req_valid = 1'b0;
        step();
        chk("abort_in_wait_busy", {63'd0, bus.busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("abort_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        chk("abort_mem_addr", {48'd0, bus.mem_addr}, 64'd0);
        chk("abort_wr_data", {32'd0, bus.wr_data}, 64'd0);
        chk("abort_rd_wr_mem", {63'd0, bus.rd_wr_mem}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_abort_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
            chk("post_abort_no_cmd", {63'd0, bus.rd_wr_valid}, 64'd0);
        end

        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = 16'hFFFF;
                1:       a = 16'h0000;
                default: a = AW'($urandom_range(0, 15));
            endcase
            do_txn(1'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        repeat (6) step();
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
